// File: rtl/inv_mixcol_sequencer.sv
// inv_mixcol_sequencer
// Time-multiplexes a single 32-bit InvMixColumns datapath over the four
// columns of a 128-bit AES decryption state, one column per clock. There is
// a valid/ready handshake on both sides. A bypass input skips the transform
// for the final decryption round.
module inv_mixcol_sequencer #(
    parameter int unsigned STATE_W  = 128,
    parameter int unsigned COL_W    = 32,
    parameter int unsigned NUM_COLS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_data,
    input  logic               in_bypass,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_data,
    output logic               busy
);

    localparam int unsigned     CNT_W    = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(NUM_COLS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   col_cnt, cnt_nx;
    logic [STATE_W-1:0] buffer, buf_nx;
    logic [STATE_W-1:0] buf_wb;
    logic [COL_W-1:0]   col_in, col_out;

    // Multiply by x in GF(2^8), reduction polynomial 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // InvMixColumns on one column; byte 0 sits at the MSB.
    function automatic logic [31:0] inv_mix(input logic [31:0] col);
        logic [7:0] s  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        logic [31:0] r;
        r = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            s[k]  = col[31-8*k -: 8];
            x2    = xtime(s[k]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[k] = x8 ^ s[k];
            mb[k] = x8 ^ x2 ^ s[k];
            md[k] = x8 ^ x4 ^ s[k];
            me[k] = x8 ^ x4 ^ x2;
        end
        for (int unsigned i = 0; i < 4; i++) begin
            r[31-8*i -: 8] = me[i] ^ mb[(i+1)%4] ^ md[(i+2)%4] ^ m9[(i+3)%4];
        end
        return r;
    endfunction

    // Select the buffer column addressed by col_cnt for the shared datapath.
    always_comb begin
        col_in = '0;
        for (int unsigned c = 0; c < NUM_COLS; c++) begin
            if (CNT_W'(c) == col_cnt) begin
                col_in = buffer[STATE_W-1-c*COL_W -: COL_W];
            end
        end
    end

    assign col_out = inv_mix(col_in);

    // Merge the transformed column back into its own slot of the buffer.
    always_comb begin
        buf_wb = buffer;
        for (int unsigned c = 0; c < NUM_COLS; c++) begin
            if (CNT_W'(c) == col_cnt) begin
                buf_wb[STATE_W-1-c*COL_W -: COL_W] = col_out;
            end
        end
    end

    // Next-state, column counter and buffer update; flush overrides all.
    always_comb begin
        state_nx = state;
        cnt_nx   = col_cnt;
        buf_nx   = buffer;
        if (flush) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        buf_nx   = in_data;
                        cnt_nx   = '0;
                        state_nx = in_bypass ? DONE : RUN;
                    end
                end
                RUN: begin
                    buf_nx = buf_wb;
                    if (col_cnt == LAST_COL) begin
                        cnt_nx   = '0;
                        state_nx = DONE;
                    end else begin
                        cnt_nx = col_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_nx = IDLE;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    // State, counter and buffer registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            col_cnt <= '0;
            buffer  <= '0;
        end else begin
            state   <= state_nx;
            col_cnt <= cnt_nx;
            buffer  <= buf_nx;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN) || (state == DONE);
    assign out_data  = buffer;

endmodule

// File: tb/tb_inv_mixcol_sequencer.sv
// Self-checking bench for inv_mixcol_sequencer against a byte-level
// GF(2^8) matrix reference model.
module tb_inv_mixcol_sequencer;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_bypass;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    int vectors;
    int miscompares;

    inv_mixcol_sequencer #(
        .STATE_W  (128),
        .COL_W    (32),
        .NUM_COLS (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_bypass (in_bypass),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Generic shift-and-add GF(2^8) multiply with 0x11B reduction.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ (16'(a) << i);
        end
        for (int i = 14; i >= 8; i--) begin
            if (p[i]) p = p ^ (16'h011b << (i - 8));
        end
        return p[7:0];
    endfunction

    // Full-state reference: circulant matrix {0e,0b,0d,09} per column.
    function automatic logic [127:0] model(input logic [127:0] s, input logic byp);
        logic [7:0]   coef [4];
        logic [7:0]   sb   [4];
        logic [7:0]   acc;
        logic [127:0] r;
        coef[0] = 8'h0e;
        coef[1] = 8'h0b;
        coef[2] = 8'h0d;
        coef[3] = 8'h09;
        if (byp) return s;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) sb[j] = s[127-32*c-8*j -: 8];
            for (int i = 0; i < 4; i++) begin
                acc = '0;
                for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef[(j - i + 4) % 4], sb[j]);
                r[127-32*c-8*i -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Present one state for a single cycle; returns at the negedge after the accept edge.
    task automatic send(input logic [127:0] d, input logic byp);
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = d;
        in_bypass = byp;
        @(negedge clk);
        in_valid  = 1'b0;
        in_data   = rand128();
        in_bypass = 1'($urandom_range(0, 1));
    endtask

    // Count clock edges until out_valid is seen, bounded.
    task automatic wait_out(output int lat, output bit timeout);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        timeout = !out_valid;
    endtask

    // One-cycle out_ready pulse from a negedge where out_valid is high.
    task automatic take();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0) begin
            miscompares++;
            $display("FAIL reset: in_ready=%b out_valid=%b busy=%b out_data=%h, required 1 0 0 0",
                     in_ready, out_valid, busy, out_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_column();
        logic [127:0] exp_d;
        int lat;
        bit to;
        exp_d = 128'hdb135345_01010101_01010101_01010101;
        send(128'h8e4da1bc_01010101_01010101_01010101, 1'b0);
        vectors++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL single_busy: busy=%b in_ready=%b, required 1 0", busy, in_ready);
        end
        wait_out(lat, to);
        vectors++;
        if (to || lat != 4) begin
            miscompares++;
            $display("FAIL single_latency: got %0d edges (timeout=%0d), required 4", lat, to);
        end
        vectors++;
        if (out_data !== exp_d) begin
            miscompares++;
            $display("FAIL single_data: got %h, required %h", out_data, exp_d);
        end
        take();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_release: in_ready=%b out_valid=%b busy=%b, required 1 0 0",
                     in_ready, out_valid, busy);
        end
    endtask

    task automatic test_fips();
        logic [127:0] exp_d;
        int lat;
        bit to;
        exp_d = 128'hf20a225c_d4d4d4d5_2d26314c_c6c6c6c6;
        send(128'h9fdc589d_d5d5d7d6_4d7ebdf8_c6c6c6c6, 1'b0);
        wait_out(lat, to);
        vectors++;
        if (to || out_data !== exp_d) begin
            miscompares++;
            $display("FAIL fips_data: got %h (timeout=%0d), required %h", out_data, to, exp_d);
        end
        take();
    endtask

    task automatic test_bypass();
        logic [127:0] d;
        int lat;
        bit to;
        d = 128'h00112233_44556677_8899aabb_ccddeeff;
        send(d, 1'b1);
        wait_out(lat, to);
        vectors++;
        if (to || lat != 0 || in_ready !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL bypass_timing: lat=%0d timeout=%0d in_ready=%b busy=%b, required 0 0 0 1",
                     lat, to, in_ready, busy);
        end
        vectors++;
        if (out_data !== d) begin
            miscompares++;
            $display("FAIL bypass_data: got %h, required %h", out_data, d);
        end
        take();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bypass_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_hold();
        logic [127:0] d, exp_d;
        int lat;
        bit to;
        d     = rand128();
        exp_d = model(d, 1'b0);
        send(d, 1'b0);
        wait_out(lat, to);
        vectors++;
        if (to) begin
            miscompares++;
            $display("FAIL hold_timeout: out_valid=%b after %0d edges, required 1", out_valid, lat);
        end
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data   = rand128();
            in_bypass = 1'($urandom_range(0, 1));
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== exp_d) begin
                miscompares++;
                $display("FAIL hold_stable[%0d]: out_valid=%b in_ready=%b data=%h, required 1 0 %h",
                         i, out_valid, in_ready, out_data, exp_d);
            end
        end
        in_valid = 1'b0;
        take();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_release: in_ready=%b out_valid=%b busy=%b, required 1 0 0",
                     in_ready, out_valid, busy);
        end
    endtask

    task automatic test_flush();
        logic [127:0] exp_d;
        int lat;
        bit to;
        bit seen;
        exp_d = 128'hdb135345_01010101_01010101_01010101;
        send(128'h8e4da1bc_01010101_01010101_01010101, 1'b0);
        repeat (2) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_idle: in_ready=%b busy=%b out_valid=%b, required 1 0 0",
                     in_ready, busy, out_valid);
        end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL flush_no_output: out_valid rose=%b, required 0", seen);
        end
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = rand128();
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_drop_input: in_ready=%b busy=%b, required 1 0", in_ready, busy);
        end
        send(128'h8e4da1bc_01010101_01010101_01010101, 1'b0);
        wait_out(lat, to);
        vectors++;
        if (to || lat != 4 || out_data !== exp_d) begin
            miscompares++;
            $display("FAIL flush_recover: lat=%0d timeout=%0d data=%h, required 4 0 %h",
                     lat, to, out_data, exp_d);
        end
        take();
    endtask

    task automatic test_random();
        logic [127:0] d, exp_d;
        logic b;
        int lat;
        bit to;
        for (int n = 0; n < 16; n++) begin
            d     = rand128();
            b     = 1'($urandom_range(0, 3) == 0);
            exp_d = model(d, b);
            send(d, b);
            wait_out(lat, to);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            vectors++;
            if (to || lat != (b ? 0 : 4) || out_data !== exp_d) begin
                miscompares++;
                $display("FAIL random[%0d]: bypass=%b lat=%0d timeout=%0d data=%h, required lat %0d data %h",
                         n, b, lat, to, out_data, b ? 0 : 4, exp_d);
            end
            take();
        end
    endtask

    task automatic test_reset_mid_run();
        send(rand128(), 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0) begin
            miscompares++;
            $display("FAIL async_reset: in_ready=%b out_valid=%b busy=%b out_data=%h, required 1 0 0 0",
                     in_ready, out_valid, busy, out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [127:0] q_exp [$];
        int           q_acc [$];
        logic         q_byp [$];
        logic [127:0] d, e;
        logic         b;
        int           acc;
        int           sent, got, cyc;
        sent      = 0;
        got       = 0;
        cyc       = 0;
        out_ready = 1'b1;
        while (got < 10 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                vectors++;
                if (q_exp.size() == 0) begin
                    miscompares++;
                    $display("FAIL b2b_spurious: out_valid=%b with nothing pending, required 0", out_valid);
                end else begin
                    e   = q_exp.pop_front();
                    acc = q_acc.pop_front();
                    b   = q_byp.pop_front();
                    if (out_data !== e || (cyc - acc) != (b ? 1 : 5)) begin
                        miscompares++;
                        $display("FAIL b2b[%0d]: data=%h lat=%0d, required %h lat %0d",
                                 got, out_data, cyc - acc, e, b ? 1 : 5);
                    end
                end
                got++;
            end
            if (in_ready && sent < 10) begin
                d         = rand128();
                b         = 1'($urandom_range(0, 2) == 0);
                in_valid  = 1'b1;
                in_data   = d;
                in_bypass = b;
                q_exp.push_back(model(d, b));
                q_acc.push_back(cyc);
                q_byp.push_back(b);
                sent++;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        vectors++;
        if (got != 10) begin
            miscompares++;
            $display("FAIL b2b_count: received %0d states, required 10", got);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        in_bypass   = 1'b0;
        out_ready   = 1'b0;
        test_reset();
        test_single_column();
        test_fips();
        test_bypass();
        test_hold();
        test_flush();
        test_random();
        test_reset_mid_run();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
